// File: rtl/zero_group_counter_mc.sv
// Multi-channel zero-group counter: round-robins NCH converters through one soc/eoc handshake
// and publishes one K-bit zero-group count per fixed PERIOD-clock slot, with channel tag and timeout.
module zero_group_counter_mc #(
   parameter int W      = 8,
   parameter int K      = 2,
   parameter int NCH    = 4,
   parameter int PERIOD = 20,
   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int CW    = $clog2(W + 1)
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [W-1:0]   x,
   input  logic           eoc,
   input  logic           mode,
   output logic           soc,
   output logic [CHW-1:0] sel,
   output logic [CW-1:0]  out,
   output logic [CHW-1:0] out_ch,
   output logic           out_valid,
   output logic           err
);

   localparam int CNTW = $clog2(PERIOD);
   localparam logic [CNTW-1:0] CNT_LAST = CNTW'(PERIOD - 2);
   localparam logic [CHW-1:0]  SEL_LAST = CHW'(NCH - 1);
   localparam logic [W-1:0]    ONES     = '1;
   localparam logic [W-1:0]    FILL_1   = ONES >> (W - 1);
   localparam logic [W-1:0]    FILL_K   = ONES >> (W - K);

   typedef enum logic [2:0] {
      S_START,
      S_WAIT,
      S_SCAN,
      S_PAD,
      S_OUT
   } state_t;

   state_t          state;
   state_t          next_state;
   logic [CNTW-1:0] cnt;
   logic [W-1:0]    shreg;
   logic [CW-1:0]   n_cnt;
   logic            mode_r;
   logic            last;
   logic            all_ones;
   logic            top_zero;
   logic            timeout;
   logic            publish;

   assign last     = (cnt == CNT_LAST);
   assign all_ones = &shreg;
   assign top_zero = (shreg[W-1 -: K] == '0);
   assign publish  = (next_state == S_OUT);

   // NOTE: every output of this block is given a default first, so no path leaves a latch behind.
   always_comb begin
      next_state = state;
      timeout    = 1'b0;
      case (state)
         S_START: begin
            if (last) begin
               next_state = S_OUT;
               timeout    = 1'b1;
            end else if (!eoc) begin
               next_state = S_WAIT;
            end
         end
         // A sample arriving on the last usable cycle has no time left to be scanned.
         S_WAIT: begin
            if (last) begin
               next_state = S_OUT;
               timeout    = 1'b1;
            end else if (eoc) begin
               next_state = S_SCAN;
            end
         end
         S_SCAN: begin
            if (last) begin
               next_state = S_OUT;
            end else if (all_ones) begin
               next_state = S_PAD;
            end
         end
         S_PAD: begin
            if (last) begin
               next_state = S_OUT;
            end
         end
         S_OUT:   next_state = S_START;
         default: next_state = S_START;
      endcase
   end

   // Result registers load on the edge entering S_OUT, so out_valid is high during the slot's last cycle.
   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_START;
         cnt       <= '0;
         soc       <= 1'b0;
         sel       <= '0;
         out       <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= next_state;
         cnt       <= (state == S_OUT) ? '0 : cnt + CNTW'(1);
         soc       <= (state == S_START);
         out_valid <= publish;
         if (publish) begin
            out    <= timeout ? '0 : n_cnt;
            err    <= timeout;
            out_ch <= sel;
         end
         if (state == S_OUT) begin
            sel <= (sel == SEL_LAST) ? '0 : sel + CHW'(1);
         end
      end
   end

   // NOTE: datapath registers carry no reset; each slot reloads them before they are ever read.
   always_ff @(posedge clock) begin
      if (state == S_START && cnt == '0) begin
         mode_r <= mode;
      end
      case (state)
         S_WAIT: begin
            shreg <= x;
            n_cnt <= '0;
         end
         S_SCAN: begin
            if (!all_ones) begin
               if (top_zero) begin
                  if (n_cnt != '1) begin
                     n_cnt <= n_cnt + CW'(1);
                  end
                  shreg <= mode_r ? ((shreg << 1) | FILL_1) : ((shreg << K) | FILL_K);
               end else begin
                  shreg <= (shreg << 1) | FILL_1;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_zero_group_counter_mc.sv
// Self-checking bench for zero_group_counter_mc: behavioural converter model plus a slot-level
// reference model that predicts every published result from the bit-pattern rules.
module tb_zero_group_counter_mc;

   localparam int W      = 8;
   localparam int K      = 2;
   localparam int NCH    = 4;
   localparam int PERIOD = 20;
   localparam int CHW    = 2;
   localparam int CW     = 4;
   localparam int SLOTS  = 50;

   typedef struct {
      logic [W-1:0] sample;
      bit           mode;
      int           delay;
      bit           hung;
      bit           glitch;
      bit           rst_mid;
      int           lit;
   } plan_t;

   logic           clock;
   logic           reset;
   logic [W-1:0]   x;
   logic           eoc;
   logic           mode;
   logic           soc;
   logic [CHW-1:0] sel;
   logic [CW-1:0]  out;
   logic [CHW-1:0] out_ch;
   logic           out_valid;
   logic           err;

   int checks;
   int failures;
   int cyc;
   int slot_idx;
   int slots_done;
   int busy;
   bit soc_prev;
   plan_t plans[$];
   plan_t cur;
   plan_t nxt;
   logic [CW-1:0]  exp_out;
   logic [CHW-1:0] exp_ch;
   logic           exp_err;
   logic           exp_valid;

   zero_group_counter_mc #(.W(W), .K(K), .NCH(NCH), .PERIOD(PERIOD)) dut (
      .clock(clock),
      .reset(reset),
      .x(x),
      .eoc(eoc),
      .mode(mode),
      .soc(soc),
      .sel(sel),
      .out(out),
      .out_ch(out_ch),
      .out_valid(out_valid),
      .err(err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (slot %0d cycle %0d, t=%0t)",
                  name, actual, expected, slot_idx, cyc, $time);
      end
   endtask

   // Mode 0: greedy non-overlapping K-zero groups from the MSB; mode 1: every K-wide all-zero window.
   function automatic int ref_count(input logic [W-1:0] s, input bit m);
      int v;
      int n;
      int i;
      int mask;
      v    = int'(s);
      mask = (1 << K) - 1;
      n    = 0;
      if (m) begin
         for (int j = 0; j <= W - K; j++) begin
            if (((v >> j) & mask) == 0) n++;
         end
      end else begin
         i = W - 1;
         while (i >= K - 1) begin
            if (((v >> (i - K + 1)) & mask) == 0) begin
               n++;
               i -= K;
            end else begin
               i--;
            end
         end
      end
      return n;
   endfunction

   function automatic plan_t mk(input logic [W-1:0] s, input bit m, input int d, input bit h,
                                input bit g, input bit r, input int lit);
      plan_t p;
      p.sample  = s;
      p.mode    = m;
      p.delay   = d;
      p.hung    = h;
      p.glitch  = g;
      p.rst_mid = r;
      p.lit     = lit;
      return p;
   endfunction

   function automatic plan_t next_plan();
      plan_t p;
      bit    h;
      if (plans.size() > 0) return plans.pop_front();
      h = ($urandom_range(0, 9) == 0);
      p = mk(W'($urandom & $urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 8), h,
             !h && ($urandom_range(0, 3) == 0), 1'b0, -1);
      return p;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_soc"}, 32'(soc), 32'd0);
      check({tag, "_sel"}, 32'(sel), 32'd0);
      check({tag, "_out"}, 32'(out), 32'd0);
      check({tag, "_out_ch"}, 32'(out_ch), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
   endtask

   // Asynchronous reset in the middle of a slot; released on the following falling edge.
   task automatic reset_mid();
      #2 reset = 1'b1;
      #1 check_all_zero("rst_mid");
      @(negedge clock);
      eoc        = 1'b1;
      x          = W'($urandom);
      busy       = 0;
      soc_prev   = 1'b0;
      cyc        = 0;
      slot_idx   = 0;
      slots_done++;
      exp_out    = '0;
      exp_ch     = '0;
      exp_err    = 1'b0;
      cur        = nxt;
      nxt        = next_plan();
      mode       = cur.mode;
      reset      = 1'b0;
   endtask

   // Called at a falling edge: checks the current cycle, drives the next one, then advances.
   task automatic step();
      int ch;
      if (cur.rst_mid && cyc == 11) begin
         reset_mid();
         return;
      end
      ch        = slot_idx % NCH;
      exp_valid = (cyc == PERIOD - 1);
      if (exp_valid) begin
         exp_out = cur.hung ? '0 : CW'(ref_count(cur.sample, cur.mode));
         exp_err = cur.hung;
         exp_ch  = CHW'(ch);
      end
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("out", 32'(out), 32'(exp_out));
      check("out_ch", 32'(out_ch), 32'(exp_ch));
      check("err", 32'(err), 32'(exp_err));
      check("sel", 32'(sel), 32'(ch));
      if (cyc == 1) check("soc_start", 32'(soc), 32'd1);
      if (cyc == 0 || cyc == PERIOD - 1) check("soc_idle", 32'(soc), 32'd0);
      if (exp_valid && cur.lit >= 0) check("directed_out", 32'(out), 32'(cur.lit));

      // Converter: a rising soc restarts a conversion; eoc drops, then rises with the sample.
      if (soc && !soc_prev) begin
         busy = cur.hung ? -1 : cur.delay;
         eoc  = 1'b0;
         x    = W'($urandom);
      end else if (busy < 0) begin
         eoc = 1'b0;
         x   = W'($urandom);
      end else if (busy > 0) begin
         busy--;
         if (busy == 0) begin
            eoc = 1'b1;
            x   = cur.sample;
         end else begin
            x = W'($urandom);
         end
      end else begin
         x = W'($urandom);
      end
      if (cur.glitch && (cyc == 14 || cyc == 15)) eoc = 1'b0;
      if (cur.glitch && cyc == 16) eoc = 1'b1;
      soc_prev = soc;
      if (cyc == 10) mode = nxt.mode;

      cyc++;
      if (cyc == PERIOD) begin
         cyc = 0;
         slot_idx++;
         slots_done++;
         cur = nxt;
         nxt = next_plan();
      end
      @(negedge clock);
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      cyc        = 0;
      slot_idx   = 0;
      slots_done = 0;
      busy       = 0;
      soc_prev   = 1'b0;
      exp_out    = '0;
      exp_ch     = '0;
      exp_err    = 1'b0;
      exp_valid  = 1'b0;

      check("model_00_m0", 32'(ref_count(8'h00, 1'b0)), 32'd4);
      check("model_33_m0", 32'(ref_count(8'h33, 1'b0)), 32'd2);
      check("model_ff_m0", 32'(ref_count(8'hFF, 1'b0)), 32'd0);
      check("model_55_m0", 32'(ref_count(8'h55, 1'b0)), 32'd0);
      check("model_00_m1", 32'(ref_count(8'h00, 1'b1)), 32'd7);
      check("model_0f_m1", 32'(ref_count(8'h0F, 1'b1)), 32'd3);

      plans.push_back(mk(8'h00, 1'b0, 2, 1'b0, 1'b0, 1'b0, 4));
      plans.push_back(mk(8'h33, 1'b0, 1, 1'b0, 1'b0, 1'b0, 2));
      plans.push_back(mk(8'hFF, 1'b0, 8, 1'b0, 1'b0, 1'b0, 0));
      plans.push_back(mk(8'h0F, 1'b0, 3, 1'b0, 1'b0, 1'b0, 2));
      plans.push_back(mk(8'h55, 1'b0, 2, 1'b0, 1'b1, 1'b0, 0));
      plans.push_back(mk(8'h00, 1'b1, 8, 1'b0, 1'b0, 1'b0, 7));
      plans.push_back(mk(8'h0F, 1'b1, 4, 1'b0, 1'b1, 1'b0, 3));
      plans.push_back(mk(8'h00, 1'b0, 2, 1'b1, 1'b0, 1'b0, 0));
      plans.push_back(mk(8'h33, 1'b1, 2, 1'b0, 1'b0, 1'b0, 2));
      plans.push_back(mk(8'h00, 1'b1, 8, 1'b0, 1'b0, 1'b1, -1));
      plans.push_back(mk(8'h33, 1'b0, 2, 1'b0, 1'b0, 1'b0, 2));

      cur   = next_plan();
      nxt   = next_plan();
      reset = 1'b1;
      eoc   = 1'b1;
      x     = '0;
      mode  = cur.mode;
      @(negedge clock);
      check_all_zero("reset");
      @(negedge clock);
      reset = 1'b0;

      while (slots_done < SLOTS) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
